// File: rtl/gate_pipe_unit.sv
// Two-stage pipelined bitwise gate unit with valid/ready handshake,
// accumulator feedback and registered zero/parity result flags.
module gate_pipe_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_y;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_y;
  logic             r_out_zero;
  logic             r_out_parity;

  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_result;

  // Handshake: in_ready sees only registered state, out_ready and reset.
  assign w_s2_free  = !r_out_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign w_in_ready = !rst && (!r_s1_valid || w_s2_free);
  assign w_accept   = in_valid && w_in_ready;

  always_comb begin
    w_a_eff  = in_acc ? r_acc : in_a;
    w_result = '0;
    case (in_op)
      OP_AND:  w_result = w_a_eff & in_b;
      OP_OR:   w_result = w_a_eff | in_b;
      OP_XOR:  w_result = w_a_eff ^ in_b;
      OP_NAND: w_result = ~(w_a_eff & in_b);
      OP_NOR:  w_result = ~(w_a_eff | in_b);
      OP_XNOR: w_result = ~(w_a_eff ^ in_b);
      OP_NOTA: w_result = ~w_a_eff;
      OP_PASS: w_result = in_b;
      default: w_result = '0;
    endcase
  end

  // Stage 1 and accumulator; a new accept wins over clearing on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_y     <= '0;
      r_acc      <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_y     <= w_result;
      r_acc      <= w_result;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 output register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_y      <= '0;
      r_out_zero   <= 1'b0;
      r_out_parity <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid  <= 1'b1;
      r_out_y      <= r_s1_y;
      r_out_zero   <= (r_s1_y == '0);
      r_out_parity <= ^r_s1_y;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_y      = r_out_y;
  assign out_zero   = r_out_zero;
  assign out_parity = r_out_parity;

endmodule

// File: tb/tb_gate_pipe_unit.sv
// Self-checking bench: three gate_pipe_unit instances (WIDTH 1, 8, 32) share
// one stimulus stream; results are compared against hand tables and a model.
module tb_gate_pipe_unit;

  typedef struct {
    logic [2:0]  op;
    logic        acc;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  e8;
    logic [31:0] e32;
    logic        e1;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_acc;
  logic        out_ready;

  logic        rdy1, rdy8, rdy32;
  logic        ov1, ov8, ov32;
  logic [0:0]  y1;
  logic [7:0]  y8;
  logic [31:0] y32;
  logic        z1, z8, z32;
  logic        p1, p8, p32;

  int n_err;
  int n_checks;
  vec_t tbl[19];

  // random-test state
  logic [7:0]  q8[$];
  logic [31:0] q32[$];
  logic        q1[$];
  logic [31:0] m32;
  logic [7:0]  m8;
  logic        m1;

  gate_pipe_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
    .in_a(in_a[0:0]), .in_b(in_b[0:0]), .in_acc(in_acc), .out_valid(ov1),
    .out_ready(out_ready), .out_y(y1), .out_zero(z1), .out_parity(p1));

  gate_pipe_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_op(in_op),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_acc(in_acc), .out_valid(ov8),
    .out_ready(out_ready), .out_y(y8), .out_zero(z8), .out_parity(p8));

  gate_pipe_unit #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .out_valid(ov32),
    .out_ready(out_ready), .out_y(y32), .out_zero(z32), .out_parity(p32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [2:0] op, input logic acc,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [7:0] e8, input logic [31:0] e32,
                              input logic e1);
    vec_t v;
    v.op = op; v.acc = acc; v.a = a; v.b = b;
    v.e8 = e8; v.e32 = e32; v.e1 = e1;
    return v;
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Compare all three instances' outputs against one expected result set.
  task automatic check_out(input string tag, input logic [7:0] e8,
                           input logic [31:0] e32, input logic e1);
    chk({tag, " valid"}, 32'({ov1, ov8, ov32}), 32'(3'b111));
    chk({tag, " y1"}, 32'(y1), 32'(e1));
    chk({tag, " y8"}, 32'(y8), 32'(e8));
    chk({tag, " y32"}, y32, e32);
    chk({tag, " zero"}, 32'({z1, z8, z32}), 32'({e1 == 1'b0, e8 == 8'd0, e32 == 32'd0}));
    chk({tag, " parity"}, 32'({p1, p8, p32}), 32'({e1, ^e8, ^e32}));
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_op    = v.op;
    in_acc   = v.acc;
    in_a     = v.a;
    in_b     = v.b;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Stream table rows back-to-back with out_ready held high.
  task automatic run_stream(input string tag, input int lo, input int n);
    for (int j = 0; j <= n; j++) begin
      if (j < n) drive(tbl[lo + j]);
      else in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk({tag, " in_ready"}, 32'({rdy1, rdy8, rdy32}), 32'(3'b111));
      @(posedge clk);
      #1;
      if (j == 0) chk({tag, " latency"}, 32'({ov1, ov8, ov32}), 32'(3'b000));
      else check_out(tag, tbl[lo + j - 1].e8, tbl[lo + j - 1].e32, tbl[lo + j - 1].e1);
    end
  endtask

  // Offer table rows while out_ready toggles; check each consumed result.
  task automatic run_toggle(input string tag, input int lo, input int n);
    int  idx_in;
    int  idx_out;
    int  cyc;
    bit  acc_now;
    idx_in = 0; idx_out = 0; cyc = 0;
    while (idx_out < n && cyc < 50) begin
      out_ready = (cyc % 2 == 0);
      if (idx_in < n) drive(tbl[lo + idx_in]);
      else in_valid = 1'b0;
      #1;
      acc_now = in_valid && rdy8;
      if (ov8 && out_ready) begin
        check_out(tag, tbl[lo + idx_out].e8, tbl[lo + idx_out].e32, tbl[lo + idx_out].e1);
        idx_out++;
      end
      @(posedge clk);
      #1;
      if (acc_now) idx_in++;
      cyc++;
    end
    chk({tag, " results"}, 32'(idx_out), 32'(n));
  endtask

  task automatic run_random();
    int   k;
    int   done;
    int   edges;
    int   stalls;
    bit   started;
    bit   acc_now;
    logic [31:0] t32, t8, t1, a_eff;
    k = 0; done = 0; edges = 0; stalls = 0; started = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 400 && done < 100; c++) begin
      if (k < 100 && !(in_valid && started && !acc_now)) begin
        in_op  = 3'($urandom_range(0, 7));
        in_a   = $urandom;
        in_b   = $urandom;
        in_acc = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      in_valid = (k < 100);
      #1;
      acc_now = in_valid && rdy8;
      if (in_valid && !rdy8) stalls++;
      if (acc_now) begin
        a_eff = in_acc ? m32 : in_a;
        t32 = ref_op(in_op, a_eff, in_b);
        a_eff = in_acc ? {24'd0, m8} : in_a;
        t8 = ref_op(in_op, a_eff, in_b);
        a_eff = in_acc ? {31'd0, m1} : in_a;
        t1 = ref_op(in_op, a_eff, in_b);
        q32.push_back(t32);
        q8.push_back(t8[7:0]);
        q1.push_back(t1[0]);
        m32 = t32; m8 = t8[7:0]; m1 = t1[0];
        k++;
        started = 1;
      end
      @(posedge clk);
      #1;
      if (started) edges++;
      if (ov8) begin
        if (q8.size() > 0) check_out("rand", q8.pop_front(), q32.pop_front(), q1.pop_front());
        else chk("rand unexpected valid", 32'(ov8), 32'(0));
        done++;
      end
    end
    in_valid = 1'b0;
    chk("rand completed", 32'(done), 32'(100));
    chk("rand cycles", 32'(edges), 32'(101));
    chk("rand stalls", 32'(stalls), 32'(0));
  endtask

  initial begin
    n_err = 0; n_checks = 0;
    m32 = '0; m8 = '0; m1 = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
    in_acc = 1'b0; out_ready = 1'b1;

    // All ops, A=0xC5 B=0x3A
    tbl[0]  = mk(3'd0, 1'b0, 32'h0000_00C5, 32'h0000_003A, 8'h00, 32'h0000_0000, 1'b0);
    tbl[1]  = mk(3'd1, 1'b0, 32'h0000_00C5, 32'h0000_003A, 8'hFF, 32'h0000_00FF, 1'b1);
    tbl[2]  = mk(3'd2, 1'b0, 32'h0000_00C5, 32'h0000_003A, 8'hFF, 32'h0000_00FF, 1'b1);
    tbl[3]  = mk(3'd3, 1'b0, 32'h0000_00C5, 32'h0000_003A, 8'hFF, 32'hFFFF_FFFF, 1'b1);
    tbl[4]  = mk(3'd4, 1'b0, 32'h0000_00C5, 32'h0000_003A, 8'h00, 32'hFFFF_FF00, 1'b0);
    tbl[5]  = mk(3'd5, 1'b0, 32'h0000_00C5, 32'h0000_003A, 8'h00, 32'hFFFF_FF00, 1'b0);
    tbl[6]  = mk(3'd6, 1'b0, 32'h0000_00C5, 32'h0000_003A, 8'h3A, 32'hFFFF_FF3A, 1'b0);
    tbl[7]  = mk(3'd7, 1'b0, 32'h0000_00C5, 32'h0000_003A, 8'h3A, 32'h0000_003A, 1'b0);
    // All ops, A=0xDEADBEEF B=0xFFFF0000
    tbl[8]  = mk(3'd0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0000, 8'h00, 32'hDEAD_0000, 1'b0);
    tbl[9]  = mk(3'd1, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0000, 8'hEF, 32'hFFFF_BEEF, 1'b1);
    tbl[10] = mk(3'd2, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0000, 8'hEF, 32'h2152_BEEF, 1'b1);
    tbl[11] = mk(3'd3, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0000, 8'hFF, 32'h2152_FFFF, 1'b1);
    tbl[12] = mk(3'd4, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0000, 8'h10, 32'h0000_4110, 1'b0);
    tbl[13] = mk(3'd5, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0000, 8'h10, 32'hDEAD_4110, 1'b0);
    tbl[14] = mk(3'd6, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0000, 8'h10, 32'h2152_4110, 1'b0);
    tbl[15] = mk(3'd7, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0000, 8'h00, 32'hFFFF_0000, 1'b0);
    // Accumulator chain
    tbl[16] = mk(3'd1, 1'b0, 32'h0000_0001, 32'h0000_0000, 8'h01, 32'h0000_0001, 1'b1);
    tbl[17] = mk(3'd1, 1'b1, 32'h0000_0000, 32'h0000_0002, 8'h03, 32'h0000_0003, 1'b1);
    tbl[18] = mk(3'd2, 1'b1, 32'h0000_0000, 32'h0000_000F, 8'h0C, 32'h0000_000C, 1'b0);

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 32'({ov1, ov8, ov32}), 32'(0));
    chk("reset y32", y32, 32'd0);
    chk("reset y8", 32'(y8), 32'd0);
    chk("reset flags", 32'({z1, z8, z32, p1, p8, p32}), 32'(0));
    chk("reset in_ready", 32'({rdy1, rdy8, rdy32}), 32'(0));
    rst = 1'b0;
    #1;
    chk("release in_ready", 32'({rdy1, rdy8, rdy32}), 32'(3'b111));
    @(posedge clk);
    #1;

    run_stream("ops_c5", 0, 8);
    drain();
    run_stream("ops_dead", 8, 8);
    drain();
    run_stream("chain", 16, 3);
    drain();
    run_toggle("chain_tog", 16, 3);
    drain();

    // Backpressure: three offered with out_ready low
    out_ready = 1'b0;
    drive(mk(3'd7, 1'b0, 32'd0, 32'h11, 8'h11, 32'h11, 1'b1));
    #1;
    chk("bp in_ready0", 32'(rdy8), 32'(1));
    @(posedge clk); #1;
    drive(mk(3'd7, 1'b0, 32'd0, 32'h22, 8'h22, 32'h22, 1'b0));
    chk("bp in_ready1", 32'({rdy1, rdy8, rdy32}), 32'(3'b111));
    @(posedge clk); #1;
    drive(mk(3'd7, 1'b0, 32'd0, 32'h33, 8'h33, 32'h33, 1'b1));
    check_out("bp first", 8'h11, 32'h11, 1'b1);
    chk("bp full", 32'({rdy1, rdy8, rdy32}), 32'(0));
    @(posedge clk); #1;
    check_out("bp hold", 8'h11, 32'h11, 1'b1);
    chk("bp still full", 32'({rdy1, rdy8, rdy32}), 32'(0));
    out_ready = 1'b1;
    #1;
    chk("bp reopen", 32'({rdy1, rdy8, rdy32}), 32'(3'b111));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("bp second", 8'h22, 32'h22, 1'b0);
    @(posedge clk); #1;
    check_out("bp third", 8'h33, 32'h33, 1'b1);
    @(posedge clk); #1;
    chk("bp empty", 32'({ov1, ov8, ov32}), 32'(0));

    // Asynchronous reset with two transactions in flight
    out_ready = 1'b0;
    drive(mk(3'd7, 1'b0, 32'd0, 32'h44, 8'h44, 32'h44, 1'b0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre-reset valid", 32'({ov1, ov8, ov32}), 32'(3'b111));
    #1 rst = 1'b1;
    #1;
    chk("async reset valid", 32'({ov1, ov8, ov32}), 32'(0));
    chk("async reset y", y32 | 32'(y8) | 32'(y1), 32'd0);
    chk("async reset in_ready", 32'({rdy1, rdy8, rdy32}), 32'(0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset idle", 32'({ov1, ov8, ov32}), 32'(0));
    out_ready = 1'b1;
    drive(mk(3'd1, 1'b1, 32'hFF, 32'h02, 8'h02, 32'h02, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("no stale output", 32'({ov1, ov8, ov32}), 32'(0));
    @(posedge clk); #1;
    check_out("acc cleared", 8'h02, 32'h02, 1'b0);
    drain();

    run_random();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
